// File: rtl/mux_2_1_helper_if.sv
// -----------------------------------------------------------------------------
// mux_2_1_helper_if
// Bundles the input word (a1, a2, b), both valid/ready handshakes and the
// selected result of the registered 2:1 selector.
//   master : producer/consumer side (drives a1, a2, b, in_valid, out_ready)
//   slave  : the selector itself   (drives in_ready, res, out_valid[, res_par])
// res_par exists only when MUX21_PARITY_EN is defined.
// -----------------------------------------------------------------------------
interface mux_2_1_helper_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic             b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res;
    logic             out_valid;
    logic             out_ready;
`ifdef MUX21_PARITY_EN
    logic             res_par;
`endif

    modport master (
        output a1, a2, b, in_valid, out_ready,
`ifdef MUX21_PARITY_EN
        input  res_par,
`endif
        input  in_ready, res, out_valid
    );

    modport slave (
        input  a1, a2, b, in_valid, out_ready,
`ifdef MUX21_PARITY_EN
        output res_par,
`endif
        output in_ready, res, out_valid
    );
endinterface

// File: rtl/mux_2_1_helper.sv
// -----------------------------------------------------------------------------
// mux_2_1_helper
// Registered 2:1 selector (res = b ? a2 : a1, bitwise over WIDTH) with a
// 2-entry skid buffer: the output register plus one skid register. in_ready
// is registered and one word per cycle flows under backpressure.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux_2_1_helper_if.slave (a1, a2, b, in_valid, in_ready,
//           res, out_valid, out_ready[, res_par])
// Optional feature: define MUX21_PARITY_EN to add res_par = ^res, carried
// through the same output/skid path as res.
// -----------------------------------------------------------------------------
module mux_2_1_helper #(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux_2_1_helper_if.slave        bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             out_valid_reg, out_valid_next;
    logic             in_ready_reg, in_ready_next;
    logic [WIDTH-1:0] sel_word;
    logic             accept;
    logic             drain;

`ifdef MUX21_PARITY_EN
    logic             res_par_reg, res_par_next;
    logic             skid_par_reg, skid_par_next;
    logic             sel_par;
    assign sel_par = ^sel_word;
`endif

    // Bitwise select; no arithmetic and no width change.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign sel_word[gi] = bus.b ? bus.a2[gi] : bus.a1[gi];
        end
    endgenerate

    // Handshake decodes depend only on control signals, so X data cannot
    // leak into the state, out_valid or in_ready registers.
    assign accept = bus.in_valid & in_ready_reg;
    assign drain  = out_valid_reg & bus.out_ready;

    always_comb begin
        state_next = state_reg;
        res_next   = res_reg;
        skid_next  = skid_reg;
`ifdef MUX21_PARITY_EN
        res_par_next  = res_par_reg;
        skid_par_next = skid_par_reg;
`endif
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    res_next   = sel_word;
`ifdef MUX21_PARITY_EN
                    res_par_next = sel_par;
`endif
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    // Replace the departing word directly: no bubble.
                    res_next = sel_word;
`ifdef MUX21_PARITY_EN
                    res_par_next = sel_par;
`endif
                end else if (accept) begin
                    skid_next  = sel_word;
`ifdef MUX21_PARITY_EN
                    skid_par_next = sel_par;
`endif
                    state_next = ST_FULL;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    res_next   = skid_reg;
`ifdef MUX21_PARITY_EN
                    res_par_next = skid_par_reg;
`endif
                    state_next = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        out_valid_next = (state_next != ST_EMPTY);
        in_ready_next  = (state_next != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            res_reg       <= '0;
            skid_reg      <= '0;
            out_valid_reg <= 1'b0;
            // Held low during reset; rises on the first edge out of reset.
            in_ready_reg  <= 1'b0;
`ifdef MUX21_PARITY_EN
            res_par_reg   <= 1'b0;
            skid_par_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            res_reg       <= res_next;
            skid_reg      <= skid_next;
            out_valid_reg <= out_valid_next;
            in_ready_reg  <= in_ready_next;
`ifdef MUX21_PARITY_EN
            res_par_reg   <= res_par_next;
            skid_par_reg  <= skid_par_next;
`endif
        end
    end

    assign bus.res       = res_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.in_ready  = in_ready_reg;
`ifdef MUX21_PARITY_EN
    assign bus.res_par   = res_par_reg;
`endif
endmodule

// File: tb/tb_mux_2_1_helper.sv
// -----------------------------------------------------------------------------
// tb_mux_2_1_helper
// Directed vectors against a WIDTH=1 and a WIDTH=8 instance sharing clk and
// rst_n. Inputs change and outputs are sampled 1 time unit after each rising
// edge. res_par checks are included when MUX21_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_2_1_helper;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux_2_1_helper_if #(.WIDTH(1)) bus1 ();
    mux_2_1_helper_if #(.WIDTH(8)) bus8 ();

    mux_2_1_helper #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_2_1_helper #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a1, input logic a2, input logic b);
        bus1.in_valid = v; bus1.a1 = a1; bus1.a2 = a2; bus1.b = b;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a1, input logic [7:0] a2, input logic b);
        bus8.in_valid = v; bus8.a1 = a1; bus8.a2 = a2; bus8.b = b;
    endtask

    initial begin
        rst_n = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        bus1.out_ready = 1'b1;
        bus8.out_ready = 1'b1;
        step(); step();
        check_val("rst_out_valid", {63'd0, bus8.out_valid}, 64'd0);
        check_val("rst_res",       {56'd0, bus8.res},       64'd0);
        check_val("rst_in_ready",  {63'd0, bus8.in_ready},  64'd0);
        rst_n = 1'b1;
        step();
        check_val("rst_release_in_ready", {63'd0, bus8.in_ready}, 64'd1);

        // WIDTH=1 vectors, consumer always ready.
        drive1(1'b1, 1'b1, 1'b1, 1'b0); step();
        check_val("w1_v0_res",       {63'd0, bus1.res},       64'd1);
        check_val("w1_v0_out_valid", {63'd0, bus1.out_valid}, 64'd1);
        drive1(1'b1, 1'b0, 1'b1, 1'b1); step();
        check_val("w1_v1_res", {63'd0, bus1.res}, 64'd1);
        drive1(1'b1, 1'b1, 1'b0, 1'b1); step();
        check_val("w1_v2_res", {63'd0, bus1.res}, 64'd0);
        drive1(1'b1, 1'b0, 1'b1, 1'b0); step();
        check_val("w1_v3_res",       {63'd0, bus1.res},       64'd0);
        check_val("w1_v3_out_valid", {63'd0, bus1.out_valid}, 64'd1);
        drive1(1'b0, 1'b1, 1'b1, 1'b1); step();
        check_val("w1_idle_out_valid", {63'd0, bus1.out_valid}, 64'd0);

        // WIDTH=8 vectors.
        drive8(1'b1, 8'h07, 8'hF0, 1'b0); step();
        check_val("w8_07_res", {56'd0, bus8.res}, 64'h07);
`ifdef MUX21_PARITY_EN
        check_val("w8_07_par", {63'd0, bus8.res_par}, 64'd1);
`endif
        drive8(1'b1, 8'h39, 8'h03, 1'b0); step();
        check_val("w8_b0_res", {56'd0, bus8.res}, 64'h39);
        drive8(1'b1, 8'h39, 8'h03, 1'b1); step();
        check_val("w8_b1_res", {56'd0, bus8.res}, 64'h03);
`ifdef MUX21_PARITY_EN
        check_val("w8_03_par", {63'd0, bus8.res_par}, 64'd0);
`endif
        drive8(1'b0, 8'hAA, 8'h55, 1'b0); step();
        check_val("w8_idle_out_valid", {63'd0, bus8.out_valid}, 64'd0);
        check_val("w8_idle_res_hold",  {56'd0, bus8.res},       64'h03);

        // Backpressure: three words offered while the consumer stalls.
        bus8.out_ready = 1'b0;
        drive8(1'b1, 8'h11, 8'hEE, 1'b0); step();
        check_val("bp_w0_in_ready", {63'd0, bus8.in_ready}, 64'd1);
        drive8(1'b1, 8'hDD, 8'h22, 1'b1); step();
        check_val("bp_full_in_ready", {63'd0, bus8.in_ready}, 64'd0);
        drive8(1'b1, 8'h33, 8'hCC, 1'b0); step();
        check_val("bp_hold_in_ready",  {63'd0, bus8.in_ready},  64'd0);
        check_val("bp_hold_res",       {56'd0, bus8.res},       64'h11);
        check_val("bp_hold_out_valid", {63'd0, bus8.out_valid}, 64'd1);
        bus8.out_ready = 1'b1;
        step();
        check_val("bp_drain1_res", {56'd0, bus8.res}, 64'h22);
        step();
        check_val("bp_drain2_res",       {56'd0, bus8.res},       64'h33);
        check_val("bp_drain2_out_valid", {63'd0, bus8.out_valid}, 64'd1);
        drive8(1'b0, 8'h00, 8'h00, 1'b0); step();
        check_val("bp_empty_out_valid", {63'd0, bus8.out_valid}, 64'd0);

        // X data must not disturb the control registers.
        drive8(1'b1, 8'hxx, 8'hxx, 1'b0); step();
        check_val("x_out_valid", {63'd0, bus8.out_valid}, 64'd1);
        check_val("x_in_ready",  {63'd0, bus8.in_ready},  64'd1);
        drive8(1'b0, 8'h00, 8'h00, 1'b0); step();
        check_val("x_drain_out_valid", {63'd0, bus8.out_valid}, 64'd0);

        // Reset while two words are held.
        bus8.out_ready = 1'b0;
        drive8(1'b1, 8'h44, 8'h00, 1'b0); step();
        drive8(1'b1, 8'h55, 8'h00, 1'b0); step();
        check_val("rst2_full_in_ready", {63'd0, bus8.in_ready}, 64'd0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        check_val("rst2_out_valid", {63'd0, bus8.out_valid}, 64'd0);
        check_val("rst2_res",       {56'd0, bus8.res},       64'd0);
        check_val("rst2_in_ready",  {63'd0, bus8.in_ready},  64'd0);
        rst_n = 1'b1;
        step();
        check_val("rst2_release_in_ready",  {63'd0, bus8.in_ready},  64'd1);
        check_val("rst2_release_out_valid", {63'd0, bus8.out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
